// File: rtl/axis_pattern_gen.sv
// axis_pattern_gen: AXI4-Stream RGB test-pattern source (bars/gradient/checker/solid), one frame per tlast.
// Define PATTERN_MOTION_EN to scroll patterns 0-2 left by one pixel per frame.
module axis_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        axis_aclk,
    input  logic        axis_aresetn,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);
    localparam int CW = ($clog2(H_ACTIVE) < 8) ? 8 : $clog2(H_ACTIVE);
    localparam int RW = ($clog2(V_ACTIVE) < 6) ? 6 : $clog2(V_ACTIVE);
    localparam logic [CW-1:0] COL_MAX = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] BAR_W = CW'(H_ACTIVE / 8);
    localparam logic [RW-1:0] ROW_MAX = RW'(V_ACTIVE - 1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]  sel_q, sel_d;
    logic [23:0] rgb_q, rgb_d;
    logic [23:0] tdata_q, tdata_d;
    logic        tlast_q, tlast_d;
    logic        done_q;
    logic [15:0] cnt_q;
    logic [CW-1:0] x;
    logic [2:0]  bar;
    logic [23:0] pix;
    logic        hs, last_hs, start, load;
`ifdef PATTERN_MOTION_EN
    localparam int CW1 = CW + 1;
    logic [CW-1:0] off_q, off_d;
    logic [CW:0]   x_sum;
`endif

    assign hs      = m_axis_tvalid & m_axis_tready;
    assign last_hs = hs & tlast_q;
    assign start   = (state_q == S_IDLE) & enable;
    assign load    = start | hs;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) state_q <= S_IDLE;
        else               state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start)                 state_d = S_STREAM;
        else if (last_hs && !enable) state_d = S_IDLE;
    end

    always_comb begin
        m_axis_tvalid = (state_q == S_STREAM);
        m_axis_tdata  = {8'h00, tdata_q};
        m_axis_tlast  = tlast_q;
        frame_done    = done_q;
        frame_cnt     = cnt_q;
    end

    // The registered pixel is computed from next-cycle coordinates and settings.
    always_comb begin
        sel_d = (start | last_hs) ? pattern_sel : sel_q;
        rgb_d = (start | last_hs) ? solid_rgb : rgb_q;
        col_d = start ? '0 : hs ? ((col_q == COL_MAX) ? '0 : col_q + CW'(1)) : col_q;
        row_d = start ? '0 : (hs && col_q == COL_MAX) ? ((row_q == ROW_MAX) ? '0 : row_q + RW'(1)) : row_q;
`ifdef PATTERN_MOTION_EN
        off_d = last_hs ? ((off_q == COL_MAX) ? '0 : off_q + CW'(1)) : off_q;
        x_sum = {1'b0, col_d} + {1'b0, off_d};
        x     = (x_sum >= CW1'(H_ACTIVE)) ? CW'(x_sum - CW1'(H_ACTIVE)) : x_sum[CW-1:0];
`else
        x     = col_d;
`endif
        bar   = 3'(x / BAR_W);
        pix   = (sel_d == 2'd0) ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} :
                (sel_d == 2'd1) ? {3{x[7:0]}} :
                (sel_d == 2'd2) ? {24{x[5] ^ row_d[5]}} : rgb_d;
        tdata_d = load ? pix : tdata_q;
        tlast_d = load ? (col_d == COL_MAX && row_d == ROW_MAX) : tlast_q;
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            col_q   <= '0;
            row_q   <= '0;
            sel_q   <= '0;
            rgb_q   <= '0;
            tdata_q <= '0;
            tlast_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            sel_q   <= sel_d;
            rgb_q   <= rgb_d;
            tdata_q <= tdata_d;
            tlast_q <= tlast_d;
            done_q  <= last_hs;
            cnt_q   <= cnt_q + 16'(last_hs);
        end
    end

`ifdef PATTERN_MOTION_EN
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) off_q <= '0;
        else               off_q <= off_d;
    end
`endif
endmodule

// File: tb/tb_axis_pattern_gen.sv
// tb_axis_pattern_gen: randomized self-checking bench for axis_pattern_gen on a reduced 64x40 frame.
module tb_axis_pattern_gen;
    localparam int H = 64;
    localparam int V = 40;
    localparam int N = H * V;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [23:0] solid_rgb = 24'h0;
    logic        tvalid;
    logic        tready = 1'b0;
    logic [31:0] tdata;
    logic        tlast;
    logic        frame_done;
    logic [15:0] frame_cnt;

    int checks = 0;
    int failures = 0;

    bit          m_idle = 1'b1;
    bit          m_done = 1'b0;
    int          m_col = 0, m_row = 0, m_off = 0;
    logic [1:0]  m_sel = 2'd0;
    logic [23:0] m_rgb = 24'h0;
    logic [15:0] m_cnt = 16'h0;

    axis_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .axis_aclk(clk), .axis_aresetn(rst_n), .enable(enable),
        .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
        .m_axis_tlast(tlast), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] ref_pix(logic [1:0] sel, logic [23:0] rgb, int col, int row);
        logic [23:0] bars [8];
        int x;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        x = col;
`ifdef PATTERN_MOTION_EN
        x = (col + m_off) % H;
`endif
        if (sel == 2'd0) return bars[x / (H / 8)];
        if (sel == 2'd1) return {3{8'(x)}};
        if (sel == 2'd2) return (((x >> 5) ^ (row >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
        return rgb;
    endfunction

    function automatic logic [50:0] exp_vec();
        logic last;
        last = !m_idle && m_col == H - 1 && m_row == V - 1;
        return {!m_idle, m_idle ? 32'h0 : {8'h00, ref_pix(m_sel, m_rgb, m_col, m_row)}, last, m_done, m_cnt};
    endfunction

    function automatic logic [50:0] obs_vec();
        return {tvalid, tvalid ? tdata : 32'h0, tvalid & tlast, frame_done, frame_cnt};
    endfunction

    // Advances the reference by one clock edge using the inputs currently driven.
    function automatic void model_step();
        m_done = 1'b0;
        if (m_idle) begin
            if (enable) begin
                m_idle = 1'b0; m_col = 0; m_row = 0; m_sel = pattern_sel; m_rgb = solid_rgb;
            end
        end else if (tready) begin
            if (m_col == H - 1 && m_row == V - 1) begin
                m_col = 0; m_row = 0; m_cnt++; m_done = 1'b1; m_off = (m_off + 1) % H;
                m_sel = pattern_sel; m_rgb = solid_rgb;
                if (!enable) m_idle = 1'b1;
            end else if (m_col == H - 1) begin
                m_col = 0; m_row++;
            end else m_col++;
        end
    endfunction

    function automatic void model_reset();
        m_idle = 1'b1; m_done = 1'b0; m_col = 0; m_row = 0; m_off = 0; m_cnt = 16'h0;
        m_sel = 2'd0; m_rgb = 24'h0;
    endfunction

    task automatic test_reset();
        model_reset();
        repeat (3) tick();
        checks++;
        if (obs_vec() !== 51'h0) begin
            failures++; $display("FAIL reset_hold got=%h exp=%h", obs_vec(), 51'h0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            model_step();
            tick();
        end
    endtask

    task automatic test_bars();
        int tl = 0, dn = 0, idx;
        logic [31:0] e;
        pattern_sel = 2'd0; enable = 1'b1; tready = 1'b1;
        for (int i = 0; i < N + 3; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL bars cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            idx = m_row * H + m_col;
            if (tvalid && m_cnt == 0 && (idx == 0 || idx == H / 8 || idx == H - 1 || idx == H)) begin
                e = (idx == H / 8) ? 32'h00FFFF00 : (idx == H - 1) ? 32'h0 : 32'h00FFFFFF;
                checks++;
                if (tdata !== e) begin
                    failures++; $display("FAIL bars_beat%0d got=%h exp=%h", idx, tdata, e);
                end
            end
            if (tvalid && tlast) tl++;
            if (frame_done) dn++;
            model_step();
            tick();
        end
        checks++;
        if (tl != 1 || dn != 1 || frame_cnt !== 16'd1) begin
            failures++; $display("FAIL bars_frame tlast=%0d done=%0d cnt=%0d exp 1/1/1", tl, dn, frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit stall = 1'b0;
        logic [31:0] pd = 32'h0;
        logic pl = 1'b0;
        pattern_sel = 2'd1;
        for (int i = 0; i < 4 * N; i++) begin
            tready = 1'($urandom % 2);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL backpressure cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            if (stall) begin
                checks++;
                if (tvalid !== 1'b1 || {tdata, tlast} !== {pd, pl}) begin
                    failures++; $display("FAIL stall_hold cyc=%0d got=%h/%b exp=%h/%b", i, tdata, tlast, pd, pl);
                end
            end
            stall = tvalid & !tready;
            pd = tdata; pl = tlast;
            model_step();
            tick();
        end
    endtask

    task automatic test_latch();
        int ph = 0, g = 0;
        pattern_sel = 2'd2; tready = 1'b1;
        while (ph < 4 && g < 4 * N) begin
            if (ph == 1 && m_row == 20) begin
                pattern_sel = 2'd3; solid_rgb = 24'h123456; ph = 2;
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL latch cyc=%0d got=%h exp=%h", g, obs_vec(), exp_vec());
            end
`ifndef PATTERN_MOTION_EN
            if (ph == 1 && tvalid && m_col == 32 && m_row == 0) begin
                checks++;
                if (tdata !== 32'h00FFFFFF) begin
                    failures++; $display("FAIL checker_32_0 got=%h exp=%h", tdata, 32'h00FFFFFF);
                end
            end
`endif
            if (ph == 3) begin
                checks++;
                if (tvalid !== 1'b1 || tdata !== 32'h00123456) begin
                    failures++; $display("FAIL solid_first got=%b/%h exp=1/%h", tvalid, tdata, 32'h00123456);
                end
                ph = 4;
            end
            model_step();
            if (m_done) ph = (ph == 0) ? 1 : (ph == 2) ? 3 : ph;
            tick();
            g++;
        end
        checks++;
        if (ph != 4) begin
            failures++; $display("FAIL latch_timeout phase=%0d exp=4", ph);
        end
    endtask

    task automatic test_enable_drop();
        int ph = 0, g = 0, idle_n = 0;
        bit saw_last = 1'b0;
        enable = 1'b1; tready = 1'b1;
        while (ph < 4 && g < 3 * N) begin
            if (ph == 0 && m_row == 20) begin enable = 1'b0; ph = 1; end
            if (ph == 2 && idle_n == 5) begin enable = 1'b1; ph = 3; end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL enable_drop cyc=%0d got=%h exp=%h", g, obs_vec(), exp_vec());
            end
            if (ph == 1 && tvalid && tlast) saw_last = 1'b1;
            if (ph == 2) idle_n++;
            if (ph == 3 && tvalid) begin
                checks++;
                if (tdata !== 32'h00123456 || !saw_last) begin
                    failures++; $display("FAIL restart_first got=%h last_seen=%b exp=%h/1", tdata, saw_last, 32'h00123456);
                end
                ph = 4;
            end
            model_step();
            if (ph == 1 && m_idle) ph = 2;
            tick();
            g++;
        end
        checks++;
        if (ph != 4) begin
            failures++; $display("FAIL enable_timeout phase=%0d exp=4", ph);
        end
    endtask

    task automatic test_reset_mid();
        int g = 0;
        bit first = 1'b1;
        pattern_sel = 2'd0; enable = 1'b1; tready = 1'b1;
        while (m_row != 30 && g < 2 * N) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL pre_reset cyc=%0d got=%h exp=%h", g, obs_vec(), exp_vec());
            end
            model_step();
            tick();
            g++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 51'h0 || tdata !== 32'h0) begin
            failures++; $display("FAIL reset_async got=%h exp=%h", obs_vec(), 51'h0);
        end
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2 * H; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            if (first && tvalid) begin
                first = 1'b0;
                checks++;
                if (tdata !== 32'h00FFFFFF || m_col != 0 || m_row != 0) begin
                    failures++; $display("FAIL post_reset_first got=%h exp=%h", tdata, 32'h00FFFFFF);
                end
            end
            model_step();
            tick();
        end
    endtask

`ifdef PATTERN_MOTION_EN
    task automatic test_motion();
        int g = 0;
        logic [31:0] e;
        pattern_sel = 2'd1; enable = 1'b1; tready = 1'b1;
        while (m_cnt < 2 && g < 3 * N) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL motion cyc=%0d got=%h exp=%h", g, obs_vec(), exp_vec());
            end
            if (tvalid && m_cnt == 1 && m_row == 0 && (m_col == 0 || m_col == H - 1)) begin
                e = (m_col == 0) ? 32'h00010101 : 32'h0;
                checks++;
                if (tdata !== e) begin
                    failures++; $display("FAIL motion_col%0d got=%h exp=%h", m_col, tdata, e);
                end
            end
            model_step();
            tick();
            g++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bars();
        test_backpressure();
        test_latch();
        test_enable_drop();
        test_reset_mid();
`ifdef PATTERN_MOTION_EN
        test_motion();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
